// File: rtl/temp_display_seq.sv
// Sequential average-temperature display stage: iterative restoring divide,
// half-up rounding, thermometer mapping and a persistence-filtered alert.
module temp_display_seq #(
    parameter int SUM_W         = 16,
    parameter int CNT_W         = 8,
    parameter int OUT_W         = 8,
    parameter int T_MIN         = 19,
    parameter int ALERT_PERSIST = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [SUM_W-1:0] sum_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [SUM_W-1:0] temp_avg_o,
    output logic [OUT_W-1:0] coded_out_o,
    output logic             alert_o,
    output logic             err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIV   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_MAP   = 2'd3;

    localparam int STEP_W = ($clog2(SUM_W) > 0) ? $clog2(SUM_W) : 1;
    localparam int PERS_W = ($clog2(ALERT_PERSIST + 1) > 0) ? $clog2(ALERT_PERSIST + 1) : 1;

    localparam logic [SUM_W-1:0]  Q_MAX     = '1;
    localparam logic [SUM_W-1:0]  T_LO      = SUM_W'(T_MIN);
    localparam logic [SUM_W-1:0]  T_HI      = SUM_W'(T_MIN + OUT_W - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);
    localparam logic [PERS_W-1:0] PERS_MAX  = PERS_W'(ALERT_PERSIST);

    logic [1:0]        state;
    logic [STEP_W-1:0] step;
    logic [SUM_W-1:0]  quo;
    logic [CNT_W:0]    rem;
    logic [CNT_W-1:0]  divisor;
    logic              zero_div;
    logic [SUM_W-1:0]  avg;
    logic [PERS_W-1:0] pers_cnt;

    logic [CNT_W+1:0]  shifted;
    logic              fits;
    logic [CNT_W:0]    diff;
    logic [CNT_W:0]    rem_next;
    logic [CNT_W+1:0]  rem_x2;
    logic              round_up;
    logic [SUM_W-1:0]  q_rounded;

    logic              in_range;
    logic [SUM_W-1:0]  offset;
    logic [OUT_W-1:0]  code;
    logic [PERS_W-1:0] pers_next;
    logic              alert_next;

    assign ready_o = (state == S_IDLE);

    // One restoring step: the shifted partial remainder can reach 2*count-1,
    // so the trial compare keeps an extra bit above the stored remainder.
    always_comb begin
        shifted  = {rem, quo[SUM_W-1]};
        fits     = (shifted >= {2'b00, divisor});
        diff     = shifted[CNT_W:0] - {1'b0, divisor};
        rem_next = fits ? diff : shifted[CNT_W:0];
    end

    always_comb begin
        rem_x2    = {rem, 1'b0};
        round_up  = (rem_x2 >= {2'b00, divisor});
        q_rounded = quo;
        if (round_up && (quo != Q_MAX)) begin
            q_rounded = quo + SUM_W'(1);
        end
    end

    // A zero divisor forces an out-of-range result regardless of the quotient.
    always_comb begin
        in_range = !zero_div && (avg >= T_LO) && (avg <= T_HI);
        offset   = avg - T_LO;
        code     = '0;
        for (int i = 0; i < OUT_W; i++) begin
            code[i] = in_range && (offset >= SUM_W'(i));
        end
    end

    always_comb begin
        pers_next = '0;
        if (!in_range) begin
            pers_next = (pers_cnt == PERS_MAX) ? pers_cnt : pers_cnt + PERS_W'(1);
        end
        alert_next = (pers_next == PERS_MAX);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            step        <= '0;
            quo         <= '0;
            rem         <= '0;
            divisor     <= '0;
            zero_div    <= 1'b0;
            avg         <= '0;
            pers_cnt    <= '0;
            done_o      <= 1'b0;
            temp_avg_o  <= '0;
            coded_out_o <= '0;
            alert_o     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        quo      <= sum_i;
                        rem      <= '0;
                        divisor  <= count_i;
                        zero_div <= (count_i == '0);
                        step     <= '0;
                        state    <= S_DIV;
                    end
                end
                S_DIV: begin
                    quo  <= {quo[SUM_W-2:0], fits};
                    rem  <= rem_next;
                    step <= step + STEP_W'(1);
                    if (step == LAST_STEP) begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    avg   <= q_rounded;
                    state <= S_MAP;
                end
                S_MAP: begin
                    temp_avg_o  <= zero_div ? '0 : avg;
                    coded_out_o <= code;
                    alert_o     <= alert_next;
                    err_o       <= zero_div;
                    pers_cnt    <= pers_next;
                    done_o      <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_display_seq.sv
// Bench for temp_display_seq: directed and random requests checked against an
// arithmetic reference model of the average, code, alert and error outputs.
module tb_temp_display_seq;

    localparam int SUM_W         = 16;
    localparam int CNT_W         = 8;
    localparam int OUT_W         = 8;
    localparam int T_MIN         = 19;
    localparam int ALERT_PERSIST = 2;
    localparam int LATENCY       = SUM_W + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [SUM_W-1:0] sum_in = '0;
    logic [CNT_W-1:0] count_in = '0;
    logic             ready;
    logic             done;
    logic [SUM_W-1:0] temp_avg;
    logic [OUT_W-1:0] coded_out;
    logic             alert;
    logic             err;

    int n_checks = 0;
    int n_pass   = 0;
    int model_pers = 0;

    temp_display_seq #(
        .SUM_W(SUM_W), .CNT_W(CNT_W), .OUT_W(OUT_W),
        .T_MIN(T_MIN), .ALERT_PERSIST(ALERT_PERSIST)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .sum_i(sum_in), .count_i(count_in),
        .ready_o(ready), .done_o(done), .temp_avg_o(temp_avg),
        .coded_out_o(coded_out), .alert_o(alert), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Reference: integer divide, half-up rounding, range test, persistence count.
    task automatic modelResult(input int s, input int c, output int avg_e, output int code_e,
                               output int alert_e, output int err_e);
        int q, r;
        bit inr;
        if (c == 0) begin
            avg_e = 0; code_e = 0; err_e = 1; inr = 0;
        end else begin
            q = s / c;
            r = s % c;
            if (2 * r >= c && q < (1 << SUM_W) - 1) q++;
            avg_e = q; err_e = 0;
            inr = (q >= T_MIN) && (q <= T_MIN + OUT_W - 1);
            code_e = inr ? ((1 << (q - T_MIN + 1)) - 1) : 0;
        end
        if (inr) model_pers = 0;
        else if (model_pers < ALERT_PERSIST) model_pers++;
        alert_e = (model_pers >= ALERT_PERSIST) ? 1 : 0;
    endtask

    task automatic waitReady();
        int w = 0;
        while (!ready && w < 50) begin
            @(negedge clk);
            w++;
        end
    endtask

    // glitch_cycle > 0 raises start for one edge while the request is in flight.
    task automatic applyStimulus(input int s, input int c, input int glitch_cycle);
        int lat = 0;
        int extra = 0;
        bit got = 0;
        int avg_e, code_e, alert_e, err_e;
        waitReady();
        if (!ready) begin
            checkOutput("ready_timeout", 32'(ready), 32'd1);
            return;
        end
        @(negedge clk);
        sum_in = SUM_W'(s);
        count_in = CNT_W'(c);
        start = 1'b1;
        @(posedge clk);
        while (lat < 40 && !got) begin
            #1;
            start = (glitch_cycle != 0 && lat + 1 == glitch_cycle);
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) checkOutput("ready_busy", 32'(ready), 32'd0);
            if (done) got = 1;
        end
        start = 1'b0;
        if (!got) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
            return;
        end
        modelResult(s, c, avg_e, code_e, alert_e, err_e);
        checkOutput("latency", 32'(lat), 32'(LATENCY));
        checkOutput("temp_avg", 32'(temp_avg), 32'(avg_e));
        checkOutput("coded_out", 32'(coded_out), 32'(code_e));
        checkOutput("alert", 32'(alert), 32'(alert_e));
        checkOutput("err", 32'(err), 32'(err_e));
        @(posedge clk);
        #1;
        checkOutput("done_pulse", 32'(done), 32'd0);
        if (glitch_cycle != 0) begin
            for (int k = 0; k < 25; k++) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            checkOutput("glitch_extra_done", 32'(extra), 32'd0);
            checkOutput("glitch_hold_avg", 32'(temp_avg), 32'(avg_e));
        end
    endtask

    task automatic resetMidDiv();
        int extra = 0;
        waitReady();
        @(negedge clk);
        sum_in = 16'd130;
        count_in = 8'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_pers = 0;
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_avg", 32'(temp_avg), 32'd0);
        checkOutput("rst_code", 32'(coded_out), 32'd0);
        checkOutput("rst_alert", 32'(alert), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checkOutput("rst_no_done", 32'(extra), 32'd0);
    endtask

    initial begin
        int c, s;
        #2;
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_avg", 32'(temp_avg), 32'd0);
        checkOutput("reset_code", 32'(coded_out), 32'd0);
        checkOutput("reset_alert", 32'(alert), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(130, 6, 0);
        applyStimulus(128, 6, 0);
        applyStimulus(129, 6, 0);
        applyStimulus(208, 8, 0);
        applyStimulus(216, 8, 0);
        applyStimulus(144, 8, 0);
        applyStimulus(152, 8, 0);
        applyStimulus(100, 10, 0);
        applyStimulus(100, 10, 0);
        applyStimulus(100, 10, 0);
        applyStimulus(200, 8, 0);
        applyStimulus(500, 0, 0);
        applyStimulus(130, 6, 5);
        resetMidDiv();
        applyStimulus(100, 10, 0);

        for (int n = 0; n < 40; n++) begin
            c = int'($urandom_range(0, 12));
            if (c == 0 || $urandom_range(0, 3) == 0) s = int'($urandom_range(0, 65535));
            else s = c * int'($urandom_range(15, 30)) + int'($urandom_range(0, c - 1));
            applyStimulus(s, c, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
